serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that succeeds the one-bit half adder cell.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, rippling the carry through a register between chunks.
- Uses a valid/ready handshake on both sides and reports carry-out and signed overflow.
- Sits between operand-producing logic and result consumers that tolerate multi-cycle latency in exchange for a short carry chain.

---
 rtl/serial_adder_pkg.sv | 23 ++
 rtl/serial_adder_chunk.sv | 25 ++
 rtl/serial_adder.sv | 166 ++++++++++++++++
 tb/tb_serial_adder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder/subtractor: state encodings and
// small elaboration-time helpers.
package serial_adder_pkg;

    // State encodings; DONE keeps the same code across the multi-cycle arithmetic blocks
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the chunk index register: clog2 of the chunk count, at least one bit
    function automatic int idx_width(input int nchunk);
        int w;
        if (nchunk > 1) begin
            w = $clog2(nchunk);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_adder_chunk.sv
// One CHUNK-bit slice of the ripple adder. Purely combinational; the top
// level feeds it one operand slice per clock and registers the carry.
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] total_s;

    // Chunk sum with carry-out; the carry into the top bit is recovered from
    // the top sum bit, which works for any CHUNK including 1
    always_comb begin
        total_s = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
        s       = total_s[CHUNK-1:0];
        co      = total_s[CHUNK];
        c_msb   = total_s[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];
    end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, carrying
// between chunks through a register. Valid/ready on both sides; results
// (sum, cout, ovf) only change on completion or reset.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("serial_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_e            state_r;
    state_e            state_next_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  acc_r;
    logic [WIDTH-1:0]  sum_r;
    logic [WIDTH-1:0]  work_s;
    logic              carry_r;
    logic              cout_r;
    logic              ovf_r;
    logic [IDXW-1:0]   idx_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              accept_s;
    logic              last_chunk_s;
    int                base_s;
    logic [CHUNK-1:0]  x_s;
    logic [CHUNK-1:0]  y_s;
    logic [CHUNK-1:0]  s_s;
    logic              co_s;
    logic              c_msb_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

    // Handshake decode and chunk selection from the current index
    always_comb begin
        accept_s     = in_valid & in_ready_r;
        last_chunk_s = (idx_r == LAST_IDX);
        base_s       = int'(idx_r) * CHUNK;
        x_s          = a_r[base_s +: CHUNK];
        y_s          = b_r[base_s +: CHUNK];
    end

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x     (x_s),
        .y     (y_s),
        .ci    (carry_r),
        .s     (s_s),
        .co    (co_s),
        .c_msb (c_msb_s)
    );

    // Partial result with the current chunk merged in; becomes the visible
    // sum only on the final chunk so the old result stays put while BUSY
    always_comb begin
        work_s                  = acc_r;
        work_s[base_s +: CHUNK] = s_s;
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (last_chunk_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register with registered handshake flags derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
        end
    end

    // Operand capture, per-chunk carry ripple and result publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            idx_r   <= '0;
        end else if (accept_s) begin
            // Subtraction is a + ~b + 1, so cin is ignored for op_sub
            a_r     <= a;
            b_r     <= op_sub ? ~b : b;
            carry_r <= op_sub ? 1'b1 : cin;
            acc_r   <= '0;
            idx_r   <= '0;
        end else if (state_r == BUSY) begin
            acc_r   <= work_s;
            carry_r <= co_s;
            if (last_chunk_s) begin
                idx_r  <= '0;
                sum_r  <= work_s;
                cout_r <= co_s;
                ovf_r  <= c_msb_s ^ co_s;
            end else begin
                idx_r  <= idx_r + IDXW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: one 32/8 instance and one 16/16
// (single-pass) instance. Stimulus pushes expected results; monitors pop
// and compare on every output handshake.
module tb_serial_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          nchk = 0;
    int          errs = 0;

    logic        in_valid32, in_ready32, cin32, op_sub32, out_valid32, out_ready32, cout32, ovf32;
    logic [31:0] a32, b32, sum32;
    logic        in_valid16, in_ready16, cin16, op_sub16, out_valid16, out_ready16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    exp_t q32[$];
    exp_t q16[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(32), .CHUNK(8)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .cin(cin32), .op_sub(op_sub32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    serial_adder #(.WIDTH(16), .CHUNK(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .op_sub(op_sub16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the 32-bit instance: compare every accepted result
    always @(negedge clk) begin
        exp_t e;
        if (out_valid32 && out_ready32) begin
            if (q32.size() == 0) begin
                chk("unexpected_out32", 64'd1, 64'd0);
            end else begin
                e = q32.pop_front();
                chk("sum32", {32'd0, sum32}, {32'd0, e.sum});
                chk("cout32", {63'd0, cout32}, {63'd0, e.cout});
                chk("ovf32", {63'd0, ovf32}, {63'd0, e.ovf});
            end
        end
    end

    // Monitor for the 16-bit single-pass instance
    always @(negedge clk) begin
        exp_t e;
        if (out_valid16 && out_ready16) begin
            if (q16.size() == 0) begin
                chk("unexpected_out16", 64'd1, 64'd0);
            end else begin
                e = q16.pop_front();
                chk("sum16", {48'd0, sum16}, {32'd0, e.sum});
                chk("cout16", {63'd0, cout16}, {63'd0, e.cout});
                chk("ovf16", {63'd0, ovf16}, {63'd0, e.ovf});
            end
        end
    end

    // Issue one operation on the 32-bit instance; returns the cycle of the accepting edge
    task automatic issue32(input logic [31:0] av, input logic [31:0] bv, input logic c, input logic s,
                           input bit push, input exp_t e, output int acc_cyc);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        a32 = av; b32 = bv; cin32 = c; op_sub32 = s; in_valid32 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready32) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            chk("ready32_timeout", 64'd0, 64'd1);
            in_valid32 = 1'b0;
            acc_cyc = cyc;
        end else begin
            if (push) q32.push_back(e);
            @(posedge clk); #1;
            acc_cyc = cyc;
            in_valid32 = 1'b0;
            // Scramble operands after acceptance: they must not matter any more
            a32 = ~av; b32 = ~bv; cin32 = ~c; op_sub32 = ~s;
        end
    endtask

    task automatic issue16(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic s,
                           input exp_t e, output int acc_cyc);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        a16 = av; b16 = bv; cin16 = c; op_sub16 = s; in_valid16 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready16) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            chk("ready16_timeout", 64'd0, 64'd1);
            in_valid16 = 1'b0;
            acc_cyc = cyc;
        end else begin
            q16.push_back(e);
            @(posedge clk); #1;
            acc_cyc = cyc;
            in_valid16 = 1'b0;
            a16 = ~av; b16 = ~bv;
        end
    endtask

    // Cycles from the accepting edge until out_valid is first seen
    task automatic latency32(input string name, input int acc_cyc, input int expn);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid32) break;
        end
        chk(name, 64'(cyc - acc_cyc), 64'(expn));
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (q32.size() == 0 && q16.size() == 0) break;
            @(negedge clk);
        end
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q16_drained", 64'(q16.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errs=%0d)", errs);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc_prev;
        exp_t none;
        none = '0;
        rst_n = 1'b0;
        in_valid32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; op_sub32 = 1'b0; out_ready32 = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; op_sub16 = 1'b0; out_ready16 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready32", {63'd0, in_ready32}, 64'd1);
        chk("rst_out_valid32", {63'd0, out_valid32}, 64'd0);
        chk("rst_sum32", {32'd0, sum32}, 64'd0);
        chk("rst_cout32", {63'd0, cout32}, 64'd0);
        chk("rst_ovf32", {63'd0, ovf32}, 64'd0);
        chk("rst_in_ready16", {63'd0, in_ready16}, 64'd1);

        // Plan 1: full carry ripple and 4-cycle latency
        issue32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, '{32'h0000_0000, 1'b1, 1'b0}, acc);
        latency32("latency32_add", acc, 4);

        // Plan 2/3: overflow, carry-in, subtraction
        issue32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, '{32'h8000_0000, 1'b0, 1'b1}, acc);
        issue32(32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0, 1'b1, '{32'h2222_2221, 1'b0, 1'b0}, acc);
        issue32(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0}, acc);
        issue32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1}, acc);
        drain();

        // Plan 4: backpressure in DONE with a pending request
        @(posedge clk); #1;
        out_ready32 = 1'b0;
        issue32(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, '{32'h0001_0000, 1'b0, 1'b0}, acc);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid32) break;
        end
        @(posedge clk); #1;
        a32 = 32'h0000_0100; b32 = 32'h0000_0001; cin32 = 1'b1; op_sub32 = 1'b1; in_valid32 = 1'b1;
        q32.push_back('{32'h0000_00FF, 1'b1, 1'b0});
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", {63'd0, out_valid32}, 64'd1);
            chk("bp_in_ready", {63'd0, in_ready32}, 64'd0);
            chk("bp_sum", {32'd0, sum32}, 64'h0001_0000);
            chk("bp_cout", {63'd0, cout32}, 64'd0);
            chk("bp_ovf", {63'd0, ovf32}, 64'd0);
        end
        @(posedge clk); #1;
        out_ready32 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_ready_after", {63'd0, in_ready32}, 64'd1);
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        @(negedge clk);
        chk("bp_pending_taken", {63'd0, in_ready32}, 64'd0);
        drain();

        // Plan 5: reset in the middle of BUSY
        issue32(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0, none, acc);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid32}, 64'd0);
        chk("arst_sum", {32'd0, sum32}, 64'd0);
        chk("arst_cout", {63'd0, cout32}, 64'd0);
        chk("arst_ovf", {63'd0, ovf32}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready32}, 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue32(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b1, '{32'h0000_0007, 1'b0, 1'b0}, acc);
        latency32("latency32_after_rst", acc, 4);
        drain();

        // Plan 6: single-pass instance
        issue16(16'h0000, 16'h0000, 1'b1, 1'b0, '{32'h0000_0001, 1'b0, 1'b0}, acc);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid16) break;
        end
        chk("latency16", 64'(cyc - acc), 64'd1);
        issue16(16'h0000, 16'h0001, 1'b0, 1'b1, '{32'h0000_FFFF, 1'b0, 1'b0}, acc);
        issue16(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{32'h0000_8000, 1'b0, 1'b1}, acc);
        drain();

        // Back-to-back accepts with in_valid held and out_ready high
        @(posedge clk); #1;
        a16 = 16'h0001; b16 = 16'h0002; cin16 = 1'b0; op_sub16 = 1'b0; in_valid16 = 1'b1;
        acc_prev = -1;
        for (int n = 0; n < 3; n++) begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (in_ready16) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) chk("b2b_ready_timeout", 64'd0, 64'd1);
            q16.push_back('{32'h0000_0003, 1'b0, 1'b0});
            @(posedge clk); #1;
            if (n == 2) in_valid16 = 1'b0;
            if (acc_prev >= 0) chk("b2b_spacing", 64'(cyc - acc_prev), 64'd3);
            acc_prev = cyc;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nchk, errs);
        $finish;
    end

endmodule
